// File: rtl/add8_pkg.sv
// Shared constants and types for the 8-bit carry-lookahead adder.
package add8_pkg;

    localparam int unsigned ADD8_WIDTH = 8;
    localparam int unsigned ADD8_SLICE = 4;

    typedef logic [ADD8_WIDTH-1:0] add8_word_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: two-level carry expansion from generate/propagate terms.
module cla4_slice
    import add8_pkg::*;
(
    input  logic [ADD8_SLICE-1:0] i_a,
    input  logic [ADD8_SLICE-1:0] i_b,
    input  logic                  i_ci,
    output logic [ADD8_SLICE-1:0] o_s,
    output logic                  o_co,
    output logic                  o_c3
);

    logic [ADD8_SLICE-1:0] w_g;
    logic [ADD8_SLICE-1:0] w_p;
    logic [ADD8_SLICE:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is flattened to sum-of-products of g, p and ci (no rippling inside the slice).
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s  = w_p ^ w_c[ADD8_SLICE-1:0];
    assign o_co = w_c[4];
    assign o_c3 = w_c[3];

endmodule

// File: rtl/add8_unit.sv
// Adder built from chained CLA slices, with combinational outputs and a one-cycle registered copy.
module add8_unit
    import add8_pkg::*;
#(
    parameter int unsigned WIDTH = ADD8_WIDTH  // multiple of ADD8_SLICE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_in_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic [WIDTH-1:0] o_sum_q,
    output logic             o_cout_q,
    output logic             o_ovf_q,
    output logic             o_out_valid
);

    localparam int NumSlices = int'(WIDTH / ADD8_SLICE);

    logic [NumSlices:0] w_carry;
    logic               w_msb_c3;

    assign w_carry[0] = i_cin;

    // Slices are chained by ripple carry; lookahead only acts within each slice.
    for (genvar i = 0; i < NumSlices; i++) begin : g_slice
        logic w_c3;

        cla4_slice u_slice (
            .i_a  (i_a[i*ADD8_SLICE +: ADD8_SLICE]),
            .i_b  (i_b[i*ADD8_SLICE +: ADD8_SLICE]),
            .i_ci (w_carry[i]),
            .o_s  (o_sum[i*ADD8_SLICE +: ADD8_SLICE]),
            .o_co (w_carry[i+1]),
            .o_c3 (w_c3)
        );

        if (i == NumSlices - 1) begin : g_msb
            assign w_msb_c3 = w_c3;
        end else begin : g_inner
            logic w_unused_c3;
            assign w_unused_c3 = w_c3;
        end
    end

    assign o_cout = w_carry[NumSlices];
    assign o_ovf  = w_msb_c3 ^ w_carry[NumSlices];

    logic [WIDTH-1:0] r_sum_q;
    logic             r_cout_q;
    logic             r_ovf_q;
    logic             r_out_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum_q     <= '0;
            r_cout_q    <= 1'b0;
            r_ovf_q     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= i_in_valid;
            if (i_in_valid) begin
                r_sum_q  <= o_sum;
                r_cout_q <= o_cout;
                r_ovf_q  <= o_ovf;
            end
        end
    end

    assign o_sum_q     = r_sum_q;
    assign o_cout_q    = r_cout_q;
    assign o_ovf_q     = r_ovf_q;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_add8_unit.sv
// Self-checking bench for add8_unit against an arithmetic reference model.
`timescale 1ns / 1ps
module tb_add8_unit;
    import add8_pkg::*;

    logic       clk;
    logic       rst;
    add8_word_t a;
    add8_word_t b;
    logic       cin;
    logic       in_valid;
    add8_word_t sum;
    logic       cout;
    logic       ovf;
    add8_word_t sum_q;
    logic       cout_q;
    logic       ovf_q;
    logic       out_valid;

    int n_checks = 0;
    int n_fails  = 0;

    // Expected registered state, advanced once per rising edge.
    add8_word_t m_sum_q;
    logic       m_cout_q;
    logic       m_ovf_q;
    logic       m_valid;

    add8_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .i_in_valid  (in_valid),
        .o_sum       (sum),
        .o_cout      (cout),
        .o_ovf       (ovf),
        .o_sum_q     (sum_q),
        .o_cout_q    (cout_q),
        .o_ovf_q     (ovf_q),
        .o_out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from plain unsigned and signed integer arithmetic.
    function automatic logic [9:0] ref_add(input add8_word_t x, input add8_word_t y,
                                           input logic c);
        int unsigned u;
        int          s;
        logic        v;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        v = (s > 127) || (s < -128);
        return {v, u[8], u[7:0]};
    endfunction

    // Model of the register stage for the inputs present at the coming edge.
    task automatic model_edge();
        logic [9:0] r;
        r = ref_add(a, b, cin);
        if (rst) begin
            m_sum_q = 8'h00; m_cout_q = 1'b0; m_ovf_q = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_sum_q = r[7:0]; m_cout_q = r[8]; m_ovf_q = r[9];
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string name);
        n_checks++;
        if ({out_valid, ovf_q, cout_q, sum_q} !== {m_valid, m_ovf_q, m_cout_q, m_sum_q}) begin
            n_fails++;
            $display("FAIL %s: got valid=%b ovf_q=%b cout_q=%b sum_q=%h, want %b %b %b %h",
                     name, out_valid, ovf_q, cout_q, sum_q, m_valid, m_ovf_q, m_cout_q, m_sum_q);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({out_valid, ovf_q, cout_q, sum_q} !== 11'h000) begin
            n_fails++;
            $display("FAIL reset_state: got valid=%b ovf_q=%b cout_q=%b sum_q=%h, want 0 0 0 00",
                     out_valid, ovf_q, cout_q, sum_q);
        end
    endtask

    task automatic test_boundaries();
        add8_word_t ta [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h7F, 8'h80};
        add8_word_t tb [6] = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h80};
        logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [9:0] want [6] = '{10'h0FF, 10'h100, 10'h1FF, 10'h010, 10'h280, 10'h300};
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i];
            #0;
            #0;
            n_checks++;
            if ({ovf, cout, sum} !== want[i]) begin
                n_fails++;
                $display("FAIL boundary_%0d: a=%h b=%h cin=%b got ovf=%b cout=%b sum=%h, want %h",
                         i, a, b, cin, ovf, cout, sum, want[i]);
            end
            #1;
        end
    endtask

    task automatic test_registered_pulse();
        rst = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, ovf_q, cout_q, sum_q} !== {3'b100, 8'h47}) begin
            n_fails++;
            $display("FAIL pulse_capture: got valid=%b ovf_q=%b cout_q=%b sum_q=%h, want 1 0 0 47",
                     out_valid, ovf_q, cout_q, sum_q);
        end
        in_valid = 1'b0; a = 8'hA5; b = 8'h5A;
        tick();
        n_checks++;
        if ({out_valid, sum_q} !== {1'b0, 8'h47}) begin
            n_fails++;
            $display("FAIL pulse_hold: got valid=%b sum_q=%h, want 0 47", out_valid, sum_q);
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, ovf_q, cout_q, sum_q} !== 11'h000) begin
            n_fails++;
            $display("FAIL reset_priority_regs: got valid=%b ovf_q=%b cout_q=%b sum_q=%h, want 0",
                     out_valid, ovf_q, cout_q, sum_q);
        end
        n_checks++;
        if ({ovf, cout, sum} !== 10'h1FE) begin
            n_fails++;
            $display("FAIL reset_priority_comb: got ovf=%b cout=%b sum=%h, want 0 1 fe",
                     ovf, cout, sum);
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_exhaustive_comb();
        logic [9:0] r;
        int         local_fails = 0;
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 512; i++) begin
            for (int j = 0; j < 256; j++) begin
                a = add8_word_t'(i >> 1); b = add8_word_t'(j); cin = i[0];
                #1;
                r = ref_add(a, b, cin);
                n_checks++;
                if ({ovf, cout, sum} !== r) begin
                    n_fails++;
                    local_fails++;
                    if (local_fails <= 10)
                        $display("FAIL exhaustive: a=%h b=%h cin=%b got %b %b %h, want %h",
                                 a, b, cin, ovf, cout, sum, r);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = add8_word_t'($urandom); b = add8_word_t'($urandom); cin = 1'($urandom);
            tick();
            check_regs("back_to_back");
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_pipeline();
        for (int i = 0; i < 4000; i++) begin
            a = add8_word_t'($urandom); b = add8_word_t'($urandom); cin = 1'($urandom);
            in_valid = 1'($urandom);
            rst = ($urandom_range(0, 31) == 0);
            tick();
            check_regs("random_pipeline");
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        m_sum_q = 8'h00; m_cout_q = 1'b0; m_ovf_q = 1'b0; m_valid = 1'b0;
        test_reset();
        test_boundaries();
        test_registered_pulse();
        test_reset_priority();
        test_exhaustive_comb();
        test_back_to_back();
        test_random_pipeline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
